// File: rtl/sa_drain_deskew.sv
// -----------------------------------------------------------------------------
// sa_drain_deskew
//
// Drains the bottom edge of a systolic array. The array emits one result row
// diagonally: column 0 first, and column COLS-1 last, one cycle later per
// column. This block does four things, in order:
//   1. Realigns the row by delaying column j by COLS-1-j register stages.
//   2. Checks that every enable in the aligned vector is set. A partially
//      valid vector is discarded and raises the sticky err_skew flag.
//   3. Requantizes each element. The value is rounded half up, arithmetically
//      shifted right, optionally passed through ReLU, then saturated to
//      O_WIDTH bits.
//   4. Buffers the requantized vectors in a small FIFO with a valid/ready
//      output.
//
// Optional feature:
//   SA_DRAIN_RELU_EN  When defined, cfg_relu=1 clamps negative results to zero
//                     after the shift. When undefined, no ReLU logic is built
//                     and cfg_relu is ignored.
//
// Ports:
//   clk, rst          Rising-edge clock and asynchronous active-high reset.
//   en_down           Per-column result valid from the array bottom edge.
//   data_down         Per-column signed partial sums. Column j occupies
//                     bits [j*L_WIDTH +: L_WIDTH].
//   cfg_shift         Requantization right-shift amount, 0..31. It is
//                     sampled when the requantized vector is registered.
//   cfg_relu          ReLU enable. It has no effect unless SA_DRAIN_RELU_EN
//                     is defined.
//   clear             Synchronous flush of the delay lines, the requant
//                     register, the FIFO and both sticky flags.
//   out_valid         FIFO is non-empty.
//   out_ready         Consumer accepts the head vector.
//   out_data          Head vector. Element j occupies bits
//                     [j*O_WIDTH +: O_WIDTH].
//   out_count         FIFO occupancy.
//   err_skew          Sticky flag: the aligned enables disagreed.
//   err_ovf           Sticky flag: an aligned vector was dropped because
//                     the FIFO was full.
// -----------------------------------------------------------------------------
module sa_drain_deskew #(
    parameter int COLS       = 5,
    parameter int L_WIDTH    = 32,
    parameter int O_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [COLS-1:0]                   en_down,
    input  logic [COLS*L_WIDTH-1:0]           data_down,
    input  logic [4:0]                        cfg_shift,
    input  logic                              cfg_relu,
    input  logic                              clear,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [COLS*O_WIDTH-1:0]           out_data,
    output logic [$clog2(FIFO_DEPTH):0]       out_count,
    output logic                              err_skew,
    output logic                              err_ovf
);

    // One extra bit of headroom, so adding the rounding constant cannot wrap.
    localparam int EW = L_WIDTH + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int VW = COLS * O_WIDTH;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Saturation bounds expressed at the wide width:
    // SAT_MAX = 2^(O_WIDTH-1)-1, and SAT_MIN is its bitwise complement.
    localparam logic signed [EW-1:0] SAT_MAX =
        {{(EW-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

`ifndef SA_DRAIN_RELU_EN
    // Without the ReLU option, cfg_relu has no function.
    logic cfg_relu_unused;
    assign cfg_relu_unused = cfg_relu;
`endif

    // -------------------------------------------------------------------------
    // Deskew delay lines
    // -------------------------------------------------------------------------
    logic [COLS-1:0]    al_en;
    logic [L_WIDTH-1:0] al_data [COLS];

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        localparam int D = COLS - 1 - gi;
        if (D == 0) begin : g_pass
            // The last column arrives last, so it needs no delay.
            assign al_en[gi]   = en_down[gi];
            assign al_data[gi] = data_down[gi*L_WIDTH +: L_WIDTH];
        end else begin : g_dly
            logic [D-1:0]       en_sr_reg;
            logic [L_WIDTH-1:0] data_sr_reg [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_sr_reg <= '0;
                    for (int k = 0; k < D; k++) data_sr_reg[k] <= '0;
                end else if (clear) begin
                    en_sr_reg <= '0;
                    for (int k = 0; k < D; k++) data_sr_reg[k] <= '0;
                end else begin
                    en_sr_reg[0]   <= en_down[gi];
                    data_sr_reg[0] <= data_down[gi*L_WIDTH +: L_WIDTH];
                    for (int k = 1; k < D; k++) begin
                        en_sr_reg[k]   <= en_sr_reg[k-1];
                        data_sr_reg[k] <= data_sr_reg[k-1];
                    end
                end
            end

            assign al_en[gi]   = en_sr_reg[D-1];
            assign al_data[gi] = data_sr_reg[D-1];
        end
    end

    logic row_valid;
    logic skew_hit;
    assign row_valid = &al_en;
    assign skew_hit  = (|al_en) & ~row_valid;

    // -------------------------------------------------------------------------
    // Requantization (combinational), one lane per column
    // -------------------------------------------------------------------------
    logic [VW-1:0] rq_vec;

    for (genvar gi = 0; gi < COLS; gi++) begin : g_rq
        logic signed [EW-1:0] ext;
        logic        [EW-1:0] half;
        logic signed [EW-1:0] sum;
        logic signed [EW-1:0] shd;
        logic signed [EW-1:0] clip_in;
        logic [O_WIDTH-1:0]   q;

        always_comb begin
            ext  = signed'({al_data[gi][L_WIDTH-1], al_data[gi]});
            half = '0;
            if (cfg_shift != 5'd0) begin
                half = EW'(1) << (cfg_shift - 5'd1);
            end
            sum     = ext + signed'(half);
            shd     = sum >>> cfg_shift;
            clip_in = shd;
`ifdef SA_DRAIN_RELU_EN
            if (cfg_relu && shd[EW-1]) begin
                clip_in = '0;
            end
`endif
            if (clip_in > SAT_MAX) begin
                q = SAT_MAX[O_WIDTH-1:0];
            end else if (clip_in < SAT_MIN) begin
                q = SAT_MIN[O_WIDTH-1:0];
            end else begin
                q = clip_in[O_WIDTH-1:0];
            end
        end

        assign rq_vec[gi*O_WIDTH +: O_WIDTH] = q;
    end

    // -------------------------------------------------------------------------
    // Requant register and sticky skew flag
    // -------------------------------------------------------------------------
    logic          rq_valid_reg;
    logic [VW-1:0] rq_data_reg;
    logic          err_skew_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq_valid_reg <= 1'b0;
            rq_data_reg  <= '0;
            err_skew_reg <= 1'b0;
        end else if (clear) begin
            rq_valid_reg <= 1'b0;
            rq_data_reg  <= '0;
            err_skew_reg <= 1'b0;
        end else begin
            rq_valid_reg <= row_valid;
            rq_data_reg  <= rq_vec;
            if (skew_hit) err_skew_reg <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    logic [VW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          err_ovf_reg;

    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    assign full    = (count_reg == CNT_FULL);
    assign pop     = out_valid && out_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push_ok = rq_valid_reg && (!full || pop);
    assign drop    = rq_valid_reg && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr_reg] <= rq_data_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            err_ovf_reg <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            err_ovf_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            unique case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
            if (drop) err_ovf_reg <= 1'b1;
        end
    end

    assign out_valid = (count_reg != '0);
    // Memory contents are not reset, so the head is masked while the FIFO is
    // empty. This keeps out_data at zero after a reset or clear.
    assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;
    assign out_count = count_reg;
    assign err_skew  = err_skew_reg;
    assign err_ovf   = err_ovf_reg;

endmodule

// File: doc/sa_drain_deskew.md
SA_DRAIN_DESKEW -- requirements
Module: sa_drain_deskew

Interface
REQ-001 Parameter COLS, default 5: number of array columns consumed.
REQ-002 Parameter L_WIDTH, default 32: width of each incoming column partial sum.
REQ-003 Parameter O_WIDTH, default 8: width of each requantized output element.
REQ-004 Parameter FIFO_DEPTH, default 4: output vector FIFO entries, power of two.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 en_down  in  COLS  per-column result valid from the systolic array bottom edge.
REQ-008 data_down  in  COLS x L_WIDTH signed  per-column accumulated result.
REQ-009 cfg_shift  in  5  arithmetic right-shift amount for requantization, 0..31.
REQ-010 cfg_relu  in  1  clamp negatives to zero (effective only per REQ-031).
REQ-011 clear  in  1  synchronous flush of pipeline, FIFO and sticky flags.
REQ-012 out_valid  out  1  FIFO non-empty.
REQ-013 out_ready  in  1  consumer accepts head vector when out_valid high.
REQ-014 out_data  out  COLS x O_WIDTH signed  head vector, element j in bits [j*O_WIDTH +: O_WIDTH].
REQ-015 out_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 err_skew  out  1  sticky: aligned enables disagreed.
REQ-017 err_ovf  out  1  sticky: aligned vector dropped because FIFO full.

Function
REQ-018 Deskew: column j SHALL be delayed by COLS-1-j register stages (enable and data), so one result row, entering at column 0 in cycle T-(COLS-1) through column COLS-1 in cycle T, appears aligned in cycle T.
REQ-019 Aligned vector valid SHALL be the AND of all aligned enables; any aligned enable set while not all set SHALL set err_skew and discard that vector.
REQ-020 Requant per element: if cfg_shift>0 add 2^(cfg_shift-1) (round half up), then arithmetic shift right by cfg_shift; computation SHALL use L_WIDTH+1 bits so rounding never wraps.
REQ-021 ReLU (when enabled) SHALL apply after shifting, before saturation.
REQ-022 Saturation SHALL clamp to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1] (default -128..127).
REQ-023 Requant result and valid SHALL be registered once; registered valid pushes the FIFO in the following cycle.
REQ-024 Latency: column-(COLS-1) element in cycle T -> out_valid high in cycle T+2 when FIFO previously empty.
REQ-025 cfg_shift/cfg_relu SHALL be sampled at the requant register; changes affect only vectors aligned afterwards.
REQ-026 FIFO pop on out_valid && out_ready; out_data SHALL remain stable while out_valid && !out_ready.
REQ-027 Push when full: accepted only if a pop occurs the same cycle; otherwise vector dropped, err_ovf set, occupancy unchanged.
REQ-028 Push and pop same cycle when empty: push accepted, no pop; pointers wrap modulo FIFO_DEPTH.
REQ-029 clear SHALL zero delay lines, requant register, FIFO pointers, out_count, err_skew, err_ovf next cycle; clear wins over simultaneous push/pop/error.

Reset
REQ-030 On rst all state SHALL go to zero asynchronously: out_valid=0, out_data=0, out_count=0, err_skew=0, err_ovf=0, all delay-line enables 0; in-flight results are discarded, and the first row accepted after reset release is the first one whose column-0 element arrives after release.

Configuration
REQ-031 Macro SA_DRAIN_RELU_EN: defined -> ReLU per REQ-021 when cfg_relu=1; undefined -> no ReLU logic, cfg_relu ignored, negatives saturate normally.

Verification
REQ-032 Row [1000,-1000,300,-5,0] skewed over cols 0..4, cfg_shift=3 -> out_data [125,-125,38,-1,0] at T+2, out_count=1.
REQ-033 Row [2^20,-2^20,127,128,-129], cfg_shift=0 -> [127,-128,127,127,-128].
REQ-034 With SA_DRAIN_RELU_EN, cfg_relu=1, row [-50,50,-1,0,7], shift 0 -> [0,50,0,0,7]; without macro -> [-50,50,-1,0,7].
REQ-035 out_ready=0, push 5 back-to-back rows -> out_count=4, err_ovf=1, first 4 rows drained in order once out_ready=1.
REQ-036 en_down[2] missing for one row -> err_skew=1, no push; clear -> err_skew=0, out_count=0.
REQ-037 rst asserted mid-row (cols 0..2 delivered) -> all outputs 0 immediately; next full row after release produces exactly one vector.
